pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the team's N-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands across STAGES register stages. Each stage ripples one WIDTH/STAGES-bit slice, and the slice carry is registered into the next stage.
- Valid/ready handshake on both sides, with backpressure, flush, carry-out, signed-overflow and zero flags.
- Sits in the execute path as a multi-cycle adder for wide/high-fmax configurations.

Parameters:
- WIDTH, 32: operand/result width in bits. Must be a multiple of STAGES.
- STAGES, 4: pipeline depth and slice count. Legal range 1..WIDTH. SLICE = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- flush  input  1  synchronous; kills all in-flight operations
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = A+B+cin; 1 = A-B-cin
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out of MSB; for sub, 1 = no borrow
- ovf  output  1  two's-complement signed overflow
- zero  output  1  sum == 0

Behaviour:
- Arithmetic:
  - Effective B = sub ? ~b : b.
  - Effective carry-in = cin ^ sub.
  - sum = A + B_eff + c_eff, truncated to WIDTH.
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero computed on the final sum.
- Results must be bit-identical to a single-cycle WIDTH-bit adder for all inputs.
- Slicing:
  - Stage k (0..STAGES-1) computes bits [k*SLICE +: SLICE] using the slice carry registered by stage k-1 (stage 0 uses c_eff).
  - Upper operand slices are skewed (delayed) so each slice is added in its own stage.
  - Already-computed lower sum slices are carried forward alongside.
- Latency: a beat accepted at edge t produces out_valid at edge t+STAGES when there are no stalls. Throughput is 1 beat/cycle.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Pipeline advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, combinational. No combinational path from in_valid to in_ready.
  - When adv = 0, all stage registers and per-stage valid bits hold.
  - sum/cout/ovf/zero stay stable while out_valid && !out_ready.
  - Bubbles (in_valid = 0) propagate as invalid stages; data in invalid stages is don't-care.
- Reset (rst = 1 at an edge):
  - All stage valid bits clear: out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight beats; none reappear.
- Flush:
  - Clears all valid bits at the edge, including a beat being accepted that same cycle.
  - Data registers may keep stale values.
  - out_valid = 0 the next cycle.
  - rst has priority over flush.
- Simultaneous events: with the pipe full and out_ready = 1, a new beat is accepted in the same cycle the oldest retires (no bubble).
- STAGES = 1: a single registered WIDTH-bit ripple add with latency 1.
- Ordering: results exit strictly in acceptance order. No reordering or drops except via rst/flush.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1. Add 0xFFFFFFFF + 0x00000001, cin=0 → 4 cycles later: sum=0x00000000, cout=1, ovf=0, zero=1. The carry must ripple through all slices.
- Add 0x7FFFFFFF + 0x00000001 → sum=0x80000000, ovf=1, cout=0. Sub 0x80000000 - 0x00000001 → sum=0x7FFFFFFF, ovf=1, cout=1.
- Sub 0x00000005 - 0x00000007 with cin=1 → sum=0xFFFFFFFD, cout=0, zero=0.
- Back-to-back stream of 100 random beats with out_ready toggling pseudo-randomly. Check:
  - every result matches the reference model, in order, with no loss or duplication;
  - outputs stay stable while stalled;
  - in_ready == !(out_valid && !out_ready).
- Fill with 3 beats, then assert flush for 1 cycle → no out_valid for those beats. A beat accepted the cycle after flush emerges at latency 4.
- Assert rst with the pipe full and out_ready=0 → next cycle out_valid=0, sum=0, in_ready=1. Repeat the directed add case for STAGES=1 (latency 1) and for WIDTH=8, STAGES=8.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: each of STAGES stages ripples one SLICE-bit
// slice and registers its carry into the next stage, with a valid/ready handshake.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic [STAGES-1:0]            vld_p;
    logic [STAGES-1:0][WIDTH-1:0] a_p;
    logic [STAGES-1:0][WIDTH-1:0] b_p;
    logic [STAGES-1:0][WIDTH-1:0] sum_p;
    logic [STAGES-1:0]            c_p;
    logic                         ovf_p;
    logic                         zero_p;

    logic [STAGES-1:0]            vld_nxt;
    logic [STAGES-1:0][WIDTH-1:0] a_nxt;
    logic [STAGES-1:0][WIDTH-1:0] b_nxt;
    logic [STAGES-1:0][WIDTH-1:0] sum_nxt;
    logic [STAGES-1:0]            c_nxt;
    logic                         ovf_nxt;
    logic                         zero_nxt;
    logic [WIDTH-1:0]             b_eff;
    logic                         adv;
    logic                         unused_ops;

    function automatic logic [SLICE:0] add_slice(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y,
                                                 input logic             c);
        return {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, c};
    endfunction

    // Carry into the MSB is recovered as a ^ b ^ s at that bit.
    function automatic logic ovf_flag(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic c_out);
        return a_msb ^ b_msb ^ s_msb ^ c_out;
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;

    always_comb begin
        logic [SLICE:0] r;
        r            = add_slice(a[SLICE-1:0], b_eff[SLICE-1:0], cin ^ sub);
        a_nxt[0]     = a;
        b_nxt[0]     = b_eff;
        sum_nxt[0]   = '0;
        sum_nxt[0][SLICE-1:0] = r[SLICE-1:0];
        c_nxt[0]     = r[SLICE];
        vld_nxt[0]   = in_valid;
        // Later stages add their own slice of the skewed operands onto the carried sum.
        for (int k = 1; k < STAGES; k++) begin
            r          = add_slice(a_p[k-1][k*SLICE +: SLICE], b_p[k-1][k*SLICE +: SLICE],
                                   c_p[k-1]);
            a_nxt[k]   = a_p[k-1];
            b_nxt[k]   = b_p[k-1];
            sum_nxt[k] = sum_p[k-1];
            sum_nxt[k][k*SLICE +: SLICE] = r[SLICE-1:0];
            c_nxt[k]   = r[SLICE];
            vld_nxt[k] = vld_p[k-1];
        end
        ovf_nxt  = ovf_flag(a_nxt[LAST][WIDTH-1], b_nxt[LAST][WIDTH-1],
                            sum_nxt[LAST][WIDTH-1], c_nxt[LAST]);
        zero_nxt = (sum_nxt[LAST] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || flush)
            vld_p <= '0;
        else if (adv)
            vld_p <= vld_nxt;

        if (rst) begin
            sum_p[LAST] <= '0;
            c_p[LAST]   <= 1'b0;
            ovf_p       <= 1'b0;
            zero_p      <= 1'b0;
        end else if (adv) begin
            a_p    <= a_nxt;
            b_p    <= b_nxt;
            sum_p  <= sum_nxt;
            c_p    <= c_nxt;
            ovf_p  <= ovf_nxt;
            zero_p <= zero_nxt;
        end
    end

    assign out_valid  = vld_p[LAST];
    assign sum        = sum_p[LAST];
    assign cout       = c_p[LAST];
    assign ovf        = ovf_p;
    assign zero       = zero_p;
    assign unused_ops = ^{a_p[LAST], b_p[LAST]};
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: table vectors, random stalled stream, flush and reset
// sequences on a 32x4 instance, plus directed adds on 32x1 and 8x8 instances.
module tb_pipelined_addsub;
    localparam int MAIN_ST = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst, flush, in_valid, out_ready, cin, sub;
    logic [31:0] a, b;
    logic        in_ready, out_valid, cout, ovf, zero;
    logic [31:0] sum;

    logic        s1_valid, s1_cin, s1_sub, s1_ordy, s1_irdy, s1_ovalid, s1_cout, s1_ovf, s1_zero;
    logic [31:0] s1_a, s1_b, s1_sum;
    logic        s8_valid, s8_cin, s8_sub, s8_ordy, s8_irdy, s8_ovalid, s8_cout, s8_ovf, s8_zero;
    logic [7:0]  s8_a, s8_b, s8_sum;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   retired = 0;
    logic lat_chk = 1'b0;
    logic last_acc = 1'b0;
    logic prev_stall = 1'b0;
    logic [31:0] st_sum;
    logic [2:0]  st_flags;
    exp_t cur_exp;
    exp_t q[$];
    vec_t vt[8];

    pipelined_addsub #(.WIDTH(32), .STAGES(MAIN_ST)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

    pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(s1_valid), .in_ready(s1_irdy),
        .a(s1_a), .b(s1_b), .cin(s1_cin), .sub(s1_sub), .out_valid(s1_ovalid), .out_ready(s1_ordy),
        .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf), .zero(s1_zero));

    pipelined_addsub #(.WIDTH(8), .STAGES(8)) dut8 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(s8_valid), .in_ready(s8_irdy),
        .a(s8_a), .b(s8_b), .cin(s8_cin), .sub(s8_sub), .out_valid(s8_ovalid), .out_ready(s8_ordy),
        .sum(s8_sum), .cout(s8_cout), .ovf(s8_ovf), .zero(s8_zero));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic c, input logic s);
        logic [31:0] ye;
        logic [32:0] f;
        exp_t r;
        ye    = s ? ~y : y;
        f     = {1'b0, x} + {1'b0, ye} + {32'd0, c ^ s};
        r.s   = f[31:0];
        r.co  = f[32];
        r.ov  = (x[31] == ye[31]) && (r.s[31] != x[31]);
        r.z   = (r.s == 32'd0);
        r.acc = 0;
        return r;
    endfunction

    // One clock of the main instance: check outputs at negedge, track accepts, realign.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_sum", sum, st_sum);
            chk("stall_flags", {cout, ovf, zero}, st_flags);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got sum=%0h with no beat outstanding", sum);
            end else begin
                e = q.pop_front();
                chk("sum", sum, e.s);
                chk("flags", {cout, ovf, zero}, {e.co, e.ov, e.z});
                if (lat_chk) chk("latency", cyc - e.acc, MAIN_ST);
                retired++;
            end
        end
        last_acc = in_valid && in_ready && !flush && !rst;
        if (rst || flush) q.delete();
        if (last_acc) begin
            cur_exp.acc = cyc;
            q.push_back(cur_exp);
        end
        prev_stall = out_valid && !out_ready && !rst && !flush;
        st_sum     = sum;
        st_flags   = {cout, ovf, zero};
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic run1(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s,
                        input logic [31:0] es, input logic eco, input logic eov, input logic ez);
        int n;
        s1_a = x; s1_b = y; s1_cin = c; s1_sub = s; s1_valid = 1'b1;
        @(posedge clk);
        #1;
        s1_valid = 1'b0;
        n = 0;
        do begin
            n++;
            @(negedge clk);
        end while (!s1_ovalid && n < 20);
        chk("s1_latency", n, 1);
        chk("s1_sum", s1_sum, es);
        chk("s1_flags", {s1_cout, s1_ovf, s1_zero}, {eco, eov, ez});
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s,
                        input logic [7:0] es, input logic eco, input logic eov, input logic ez);
        int n;
        s8_a = x; s8_b = y; s8_cin = c; s8_sub = s; s8_valid = 1'b1;
        @(posedge clk);
        #1;
        s8_valid = 1'b0;
        n = 0;
        do begin
            n++;
            @(negedge clk);
        end while (!s8_ovalid && n < 20);
        chk("s8_latency", n, 8);
        chk("s8_sum", s8_sum, es);
        chk("s8_flags", {s8_cout, s8_ovf, s8_zero}, {eco, eov, ez});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        logic have;

        vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[2] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vt[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0};
        vt[4] = '{32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0, 1'b0};
        vt[5] = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vt[7] = '{32'h000000FF, 32'h00000000, 1'b1, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        s1_valid = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0; s1_sub = 1'b0; s1_ordy = 1'b1;
        s8_valid = 1'b0; s8_a = '0; s8_b = '0; s8_cin = 1'b0; s8_sub = 1'b0; s8_ordy = 1'b1;
        cur_exp = model(32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, ovf, zero}, 3'b000);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_s1", {s1_irdy, s1_ovalid, s1_sum[0], s1_cout, s1_ovf, s1_zero}, 6'b100000);
        chk("rst_s8", {s8_irdy, s8_ovalid, s8_sum[0], s8_cout, s8_ovf, s8_zero}, 6'b100000);

        // Table vectors back-to-back with the consumer always ready.
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = vt[i].a; b = vt[i].b; cin = vt[i].cin; sub = vt[i].sub; in_valid = 1'b1;
            cur_exp.s = vt[i].s; cur_exp.co = vt[i].co; cur_exp.ov = vt[i].ov; cur_exp.z = vt[i].z;
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Random stream with a stalling consumer.
        lat_chk = 1'b0;
        acc = 0;
        retired = 0;
        have = 1'b0;
        for (int c = 0; c < 2000 && acc < 100; c++) begin
            if (!have) begin
                a = $urandom; b = $urandom;
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cur_exp = model(a, b, cin, sub);
            tick();
            if (last_acc) begin
                acc++;
                have = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("random_accepted", acc, 100);
        chk("random_retired", retired, 100);

        // Flush three in-flight beats, then a fresh beat right after.
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h1000 + 32'(i); b = 32'h0000_0100; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            cur_exp = model(a, b, cin, sub);
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        a = 32'hAAAA0000; b = 32'h5555FFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        cur_exp = model(a, b, cin, sub);
        tick();
        in_valid = 1'b0;
        drain();

        // A beat offered in the flush cycle itself must be dropped.
        a = 32'h00000123; b = 32'h00000456; in_valid = 1'b1; flush = 1'b1;
        cur_exp = model(a, b, cin, sub);
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        repeat (6) tick();

        // Reset with the pipe full and the consumer stalled.
        lat_chk = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 32'(i + 1) * 32'h01010101; b = 32'h00000003; cin = 1'b0; sub = 1'b0;
            cur_exp = model(a, b, cin, sub);
            tick();
        end
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (8) tick();

        // Single-stage and bit-per-stage configurations.
        run1(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        run1(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
